// File: rtl/dmem_pkg.sv
// Shared types and defaults for the clocked data memory controller.
// Optional build macro used by dmem_ctrl: DMEM_STICKY_ERR_EN.
package dmem_pkg;

  // Request address bus width (full word address as decoded by the memory stage)
  localparam int DMEM_ADDR_W     = 64;

  // Default configuration
  localparam int DMEM_DATA_W     = 64;
  localparam int DMEM_DEPTH      = 8192;
  localparam int DMEM_ADDR_LIMIT = 258;
  localparam int DMEM_READ_LAT   = 1;

  // Read latency bounds and the counter that covers them
  localparam int MAX_READ_LAT    = 4;
  localparam int LAT_CNT_W       = $clog2(MAX_READ_LAT);

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Full-width range check: any address at or above the limit is illegal
  function automatic logic addr_legal(input logic [DMEM_ADDR_W-1:0] addr,
                                      input logic [DMEM_ADDR_W-1:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, synchronous registered read.
// The read register only updates on a read enable, so a sampled word is held
// for as long as the controller needs it. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read register holds its value unless a new read is issued
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  // Storage write and read-register update
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Clocked data memory controller: valid/ready request channel, one-cycle
// response strobe, configurable read latency, range checking and error status.
// Optional build macro: DMEM_STICKY_ERR_EN -- when defined, err_sticky latches
// any range error until reset; when undefined, err_sticky is tied low.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int ADDR_LIMIT = DMEM_ADDR_LIMIT,
  parameter int READ_LAT   = DMEM_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              err_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DMEM_ADDR_W-1:0] LIMIT_W  = DMEM_ADDR_W'(ADDR_LIMIT);
  localparam logic [LAT_CNT_W-1:0]   CNT_LOAD = LAT_CNT_W'(READ_LAT - 1);
  localparam logic [LAT_CNT_W-1:0]   CNT_ONE  = LAT_CNT_W'(1);

  // Reject configurations the controller cannot honour
  if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_read_lat
    $error("dmem_ctrl: READ_LAT=%0d outside 1..%0d", READ_LAT, MAX_READ_LAT);
  end
  if (ADDR_LIMIT > DEPTH) begin : g_bad_addr_limit
    $error("dmem_ctrl: ADDR_LIMIT=%0d exceeds DEPTH=%0d", ADDR_LIMIT, DEPTH);
  end

  dmem_state_e          state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 wr_q, wr_d;

  logic                 accept;
  logic                 legal;
  logic                 arr_we;
  logic                 arr_re;
  logic [DATA_W-1:0]    arr_rdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign legal     = addr_legal(req_addr, LIMIT_W);

  // Array access happens only at the accept edge and only for legal addresses;
  // reset edges never touch storage.
  assign arr_we = rst_n && accept && legal && req_write;
  assign arr_re = rst_n && accept && legal && !req_write;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  // Next-state logic: accept in IDLE, count down read latency in WAIT, pulse in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = !legal;
          wr_d  = req_write;
          if (req_write || (READ_LAT == 1)) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  // Response muxing: data only for a legal read, and only in RESP
  always_comb begin
    resp_valid = (state_q == RESP);
    resp_error = resp_valid && err_q;
    resp_rdata = '0;
    if (resp_valid && !err_q && !wr_q) resp_rdata = arr_rdata;
  end

`ifdef DMEM_STICKY_ERR_EN
  logic err_sticky_q, err_sticky_d;

  // Sticky error sets on the closing edge of an erroring response
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (resp_error) err_sticky_d = 1'b1;
  end

  // Sticky error register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) err_sticky_q <= 1'b0;
    else        err_sticky_q <= err_sticky_d;
  end

  assign err_sticky = err_sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (READ_LAT 1, 3, 4) checked every cycle
// against a cycle-indexed transaction model, plus directed literal checks.
module tb_dmem_ctrl;

  localparam int N = 3;
  localparam logic [63:0] LIMIT = 64'd258;
`ifdef DMEM_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [N];
  logic        req_write [N];
  logic [63:0] req_addr  [N];
  logic [63:0] req_wdata [N];
  logic        req_ready [N];
  logic        resp_valid[N];
  logic [63:0] resp_rdata[N];
  logic        resp_error[N];
  logic        err_sticky[N];

  int     n_cmp = 0;
  int     n_bad = 0;
  longint ecnt  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_ctrl #(
      .DATA_W     (64),
      .DEPTH      (8192),
      .ADDR_LIMIT (258),
      .READ_LAT   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_error (resp_error[g]),
      .err_sticky (err_sticky[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL i%0d %s: got %h expected %h (t=%0t)", i, nm, act, exp, $time);
    end
  endtask

  // Transaction model: each accepted request books a busy window and a
  // response slot in absolute cycle numbers. Sample k = cycle after edge k.
  longint      m_busy_end  [N];
  longint      m_resp_idx  [N];
  longint      m_acc_edge  [N];
  logic [63:0] m_resp_data [N];
  bit          m_resp_err  [N];
  bit          m_resp_known[N];
  bit          m_sticky    [N];
  bit          m_acc       [N];
  logic [63:0] mmem   [N][0:511];
  bit          mknown [N][0:511];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_busy_end[i] = -1; m_resp_idx[i] = -10; m_acc_edge[i] = 0;
      m_resp_data[i] = '0; m_resp_err[i] = 0; m_resp_known[i] = 1;
      m_sticky[i] = 0; m_acc[i] = 0;
    end
  end

  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      if (!rst_n) begin
        m_busy_end[i] = -1;
        m_resp_idx[i] = -10;
        m_sticky[i]   = 0;
      end else begin
        if (STICKY && (m_resp_idx[i] == ecnt - 1) && m_resp_err[i]) m_sticky[i] = 1;
        if ((ecnt - 1 > m_busy_end[i]) && (req_valid[i] === 1'b1)) begin
          automatic bit ok = (req_addr[i] < LIMIT);
          automatic int L  = req_write[i] ? 1 : lat_of(i);
          m_acc[i]        = 1;
          m_acc_edge[i]   = ecnt;
          m_busy_end[i]   = ecnt + L - 1;
          m_resp_idx[i]   = ecnt + L - 1;
          m_resp_err[i]   = !ok;
          m_resp_data[i]  = '0;
          m_resp_known[i] = 1;
          if (ok && req_write[i]) begin
            mmem[i][req_addr[i][8:0]]   = req_wdata[i];
            mknown[i][req_addr[i][8:0]] = 1;
          end else if (ok) begin
            m_resp_data[i]  = mmem[i][req_addr[i][8:0]];
            m_resp_known[i] = mknown[i][req_addr[i][8:0]];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (ecnt >= 1) begin
      for (int i = 0; i < N; i++) begin
        automatic bit v = (ecnt == m_resp_idx[i]);
        chk(i, "req_ready", req_ready[i], (ecnt > m_busy_end[i]));
        chk(i, "resp_valid", resp_valid[i], v);
        chk(i, "resp_error", resp_error[i], v && m_resp_err[i]);
        if (!v || m_resp_known[i])
          chk(i, "resp_rdata", resp_rdata[i], v ? m_resp_data[i] : 64'd0);
        chk(i, "err_sticky", err_sticky[i], m_sticky[i]);
      end
    end
  end

  // One request: drive, wait for acceptance, then observe the response.
  // With hold set the request stays valid and the task returns at the response.
  task automatic xact(input int i, input bit wr, input logic [63:0] a, input logic [63:0] d,
                      input bit hold, output logic [63:0] rd, output bit er,
                      output int lat, output int busy, output longint acc_e);
    bit got;
    rd = '0; er = 0; lat = 0; busy = 0; acc_e = 0;
    @(negedge clk);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      got = m_acc[i];
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL i%0d accept timeout addr %h", i, a);
      req_valid[i] = 1'b0;
      return;
    end
    acc_e = m_acc_edge[i];
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (!hold) req_valid[i] = 1'b0;
      lat++;
      if (req_ready[i] !== 1'b1) busy++;
      if (resp_valid[i] === 1'b1) begin
        rd = resp_rdata[i]; er = resp_error[i]; got = 1;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL i%0d response timeout addr %h", i, a);
    end
    if (!hold) begin
      for (int k = 0; k < 20 && req_ready[i] !== 1'b1; k++) begin
        @(negedge clk);
        if (req_ready[i] !== 1'b1) busy++;
      end
    end
  endtask

  initial begin
    logic [63:0] rd;
    bit          er;
    int          lat, busy, nv;
    longint      e1, e2;
    bit          got;

    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk(i, "reset ready", req_ready[i], 1);
      chk(i, "reset valid", resp_valid[i], 0);
      chk(i, "reset sticky", err_sticky[i], 0);
    end

    // Write 0xDEADBEEF to addr 5 on every instance
    for (int i = 0; i < N; i++) begin
      xact(i, 1, 64'd5, 64'hDEADBEEF, 0, rd, er, lat, busy, e1);
      chk(i, "wr5 latency", lat, 1);
      chk(i, "wr5 rdata", rd, 64'd0);
      chk(i, "wr5 error", er, 0);
    end

    // READ_LAT=1 read
    xact(0, 0, 64'd5, 64'd0, 0, rd, er, lat, busy, e1);
    chk(0, "rd5 latency", lat, 1);
    chk(0, "rd5 rdata", rd, 64'hDEADBEEF);

    // READ_LAT=3 read, held valid into a second read
    xact(1, 0, 64'd5, 64'd0, 1, rd, er, lat, busy, e1);
    chk(1, "rd5 lat3 latency", lat, 3);
    chk(1, "rd5 lat3 rdata", rd, 64'hDEADBEEF);
    xact(1, 0, 64'd5, 64'd0, 0, rd, er, lat, busy, e2);
    chk(1, "lat3 accept spacing", e2 - e1, 4);
    chk(1, "lat3 busy cycles", busy, 3);
    chk(1, "rd5 lat3 second rdata", rd, 64'hDEADBEEF);

    // Range checking at the limit
    xact(0, 1, 64'd257, 64'h5555, 0, rd, er, lat, busy, e1);
    xact(0, 1, 64'd258, 64'h1234, 0, rd, er, lat, busy, e1);
    chk(0, "wr258 error", er, 1);
    chk(0, "wr258 latency", lat, 1);
    xact(0, 0, 64'd258, 64'd0, 0, rd, er, lat, busy, e1);
    chk(0, "rd258 error", er, 1);
    chk(0, "rd258 rdata", rd, 64'd0);
    xact(0, 0, 64'd257, 64'd0, 0, rd, er, lat, busy, e1);
    chk(0, "rd257 error", er, 0);
    chk(0, "rd257 rdata", rd, 64'h5555);
    xact(0, 0, 64'h1_0000_0005, 64'd0, 0, rd, er, lat, busy, e1);
    chk(0, "rd high-bit addr error", er, 1);

    // Back-to-back write then read of the same address
    xact(0, 1, 64'd7, 64'hAA, 1, rd, er, lat, busy, e1);
    xact(0, 0, 64'd7, 64'd0, 0, rd, er, lat, busy, e2);
    chk(0, "b2b accept spacing", e2 - e1, 2);
    chk(0, "b2b rdata", rd, 64'hAA);

    // Reset during WAIT of a READ_LAT=4 read
    xact(2, 1, 64'd9, 64'h99, 0, rd, er, lat, busy, e1);
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 64'd9;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      got = m_acc[2];
    end
    chk(2, "lat4 accepted", got, 1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    nv = (resp_valid[2] === 1'b1) ? 1 : 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk(2, "ready after mid reset", req_ready[2], 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid[2] === 1'b1) nv++;
    end
    chk(2, "dropped response count", nv, 0);
    xact(2, 0, 64'd9, 64'd0, 0, rd, er, lat, busy, e1);
    chk(2, "rd9 after reset", rd, 64'h99);
    chk(2, "rd9 lat4 latency", lat, 4);
    xact(2, 0, 64'd5, 64'd0, 0, rd, er, lat, busy, e1);
    chk(2, "rd5 after reset", rd, 64'hDEADBEEF);

    // Sticky error behaviour
    xact(0, 0, 64'd300, 64'd0, 0, rd, er, lat, busy, e1);
    chk(0, "rd300 error", er, 1);
    xact(0, 0, 64'd5, 64'd0, 0, rd, er, lat, busy, e1);
    chk(0, "rd5 after error", rd, 64'hDEADBEEF);
    chk(0, "sticky after legal read", err_sticky[0], STICKY);
    repeat (3) @(negedge clk);
    chk(0, "sticky persists", err_sticky[0], STICKY);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk(0, "sticky cleared by reset", err_sticky[0], 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: compared %0d, mismatched %0d", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Clocked, parametrised successor to the processor's combinational data memory.
- Single-port word-addressed storage behind a valid/ready request channel and a one-cycle response pulse.
- Adds configurable read latency, range checking and an error status.
- Sits between the memory-stage address/data/read/write decode and write-back; the processor stage stalls on req_ready.

Parameters:
- DATA_W, 64: data word width in bits.
- DEPTH, 8192: storage depth in words.
- ADDR_LIMIT, 258: first illegal word address. Any address >= ADDR_LIMIT is an error. Must satisfy ADDR_LIMIT <= DEPTH.
- READ_LAT, 1: read latency in cycles, legal range 1..4. Writes always use latency 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  64  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_error  out  1  range error for this response.
- err_sticky  out  1  latched error (see Optional Feature).

Behaviour:
- Reset (clk edge with rst_n=0):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, err_sticky=0, latency counter=0.
  - Memory contents are not cleared.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. Only one request is outstanding at a time.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. On acceptance:
    - A write, or any request with READ_LAT=1, goes to RESP.
    - A read with READ_LAT>1 loads the counter with READ_LAT-1 and goes to WAIT.
  - WAIT: req_ready=0. The counter decrements each edge; when it reaches 1, the FSM goes to RESP on the next edge.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - For a read accepted at edge E0, resp_valid is high in the cycle following edge E0+READ_LAT-1.
  - Write response: the cycle after E0.
  - Throughput is one request per READ_LAT+1 cycles (reads) or 2 cycles (writes).
- Legal write (req_addr < ADDR_LIMIT): mem[req_addr] <= req_wdata at E0.
- Legal read: data is sampled from the array at E0, held in the pipeline and presented on resp_rdata during RESP.
- Error (req_addr >= ADDR_LIMIT, full 64-bit compare):
  - No array access; the write is suppressed.
  - Response timing is unchanged.
  - resp_error=1 and resp_rdata=0 in RESP.
- Outside RESP, resp_rdata=0 and resp_error=0.
- req_valid, req_addr, req_wdata and req_write are ignored while req_ready=0.
- Back-to-back requests:
  - A request held valid through RESP is accepted on the edge after RESP (first IDLE cycle).
  - A read of an address written by the immediately preceding request returns the new data.
- Reset mid-operation: the pending response is dropped with no resp_valid pulse. A write already performed at E0 persists.
- Illegal READ_LAT: elaboration error via generate-time check.

Optional Feature:
- Macro: DMEM_STICKY_ERR_EN.
- Defined: err_sticky sets on the RESP cycle's closing edge when resp_error=1. It stays 1 until reset; there is no other clear.
- Undefined: err_sticky is tied to 0 and no register is inferred. All other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - FSM state enum (IDLE, WAIT, RESP).
  - Default width/depth/limit constants.
  - MAX_READ_LAT=4 and counter width.
- One sub-module, dmem_array: synchronous-write, synchronous-read single-port storage (DATA_W x DEPTH).
- FSM, range check, latency pipeline and response muxing live in dmem_ctrl.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5, then read addr 5 with READ_LAT=1 → write resp_valid 1 cycle after accept with rdata 0 and error 0; read resp_rdata=0xDEADBEEF exactly 1 cycle after accept.
- READ_LAT=3: read addr 5 → req_ready low 3 cycles; resp_valid in the 3rd cycle after the accept edge; no second accept before IDLE.
- Write 0x1234 to addr 258 (ADDR_LIMIT) → resp_error=1. A following read of addr 258 returns error and rdata 0. A read of addr 257 has no error, and mem[257] is unchanged by the suppressed write.
- req_valid held high for write addr 7 = 0xAA followed by read addr 7 → second accept on the first IDLE edge; read returns 0xAA.
- rst_n low during WAIT of a READ_LAT=4 read → no resp_valid; req_ready=1 after reset; earlier written data still readable.
- With DMEM_STICKY_ERR_EN: error at addr 300, then legal read → err_sticky=1 persists until rst_n=0. Without the macro → err_sticky stays 0.
